// File: rtl/adder_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter_pkg
//   Shared definitions for the shared-adder arbiter slice: datapath widths,
//   the sequencing FSM state encoding and its width.
//   No ports; imported by adder_32bit and adder_share_arbiter.
// ---------------------------------------------------------------------------
package adder_share_arbiter_pkg;

    // One adder pass is 32 bits wide; a wide operation is two chained passes.
    localparam int LANE_W = 32;
    localparam int OP_W   = 64;

    // Sequencer state encoding.
    localparam int ST_W   = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

endpackage

// File: rtl/adder_share_arbiter_adder_32bit.sv
// ---------------------------------------------------------------------------
// adder_32bit
//   The single shared 32-bit adder. Purely combinational.
//   Ports:
//     Sum  out 32  A + B + C, modulo 2^32
//     Cout out 1   carry out of bit 31
//     A    in  32  operand A
//     B    in  32  operand B
//     C    in  1   carry in
// ---------------------------------------------------------------------------
module adder_32bit
    import adder_share_arbiter_pkg::*;
(
    output logic [LANE_W-1:0] Sum,
    output logic              Cout,
    input  logic [LANE_W-1:0] A,
    input  logic [LANE_W-1:0] B,
    input  logic              C
);

    // Widen by one bit so the carry out falls out of the same addition.
    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{LANE_W{1'b0}}, C};

endmodule

// File: rtl/adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter
//   Shares one adder_32bit among NREQ requesters using round-robin
//   arbitration. Narrow requests take one adder pass (32 bits); wide requests
//   take two passes, low half first, with the carry chained into the high
//   half. Each result is returned over a valid/ready handshake, tagged with
//   the id of the requester that owns it.
//
//   Ports:
//     clk        in   1        rising-edge clock
//     reset      in   1        asynchronous, active-high reset
//     req        in   NREQ     request level per requester, held until gnt
//     req_wide   in   NREQ     1 = 64-bit add, 0 = 32-bit add
//     req_a      in   NREQ*64  operand A, lane i = [64i+63:64i]
//     req_b      in   NREQ*64  operand B, same lane layout
//     req_cin    in   NREQ     carry in per requester
//     gnt        out  NREQ     one-hot accept pulse; operands captured then
//     busy       out  1        high whenever the sequencer is not idle
//     rsp_valid  out  1        result available
//     rsp_ready  in   1        consumer takes the result
//     rsp_id     out  IDW      requester that owns the result
//     rsp_sum    out  64       sum; upper half is zero for narrow ops
//     rsp_cout   out  1        carry out of the final pass
// ---------------------------------------------------------------------------
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_wide,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [OP_W-1:0]      rsp_sum,
    output logic                 rsp_cout
);

    arb_state_t          state;
    arb_state_t          next_state;

    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      winner;
    logic                any_req;

    logic [OP_W-1:0]     lane_a [NREQ];
    logic [OP_W-1:0]     lane_b [NREQ];

    logic [OP_W-1:0]     op_a;
    logic [OP_W-1:0]     op_b;
    logic                op_cin;
    logic                op_wide;
    logic [IDW-1:0]      op_id;

    logic [LANE_W-1:0]   lo;
    logic [LANE_W-1:0]   hi;
    logic                carry;

    logic [LANE_W-1:0]   add_a;
    logic [LANE_W-1:0]   add_b;
    logic                add_c;
    logic [LANE_W-1:0]   add_sum;
    logic                add_cout;

    // Round-robin pick: the first set request found scanning upward from the
    // slot just after the previous winner, wrapping past NREQ-1 back to 0.
    // Offsets are walked from farthest to nearest so the nearest set request
    // is the one left standing.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0]  pick;
        logic [NREQ-1:0] shifted;
        int              idx;
        pick = '0;
        for (int off = NREQ; off >= 1; off--) begin
            idx     = (int'(ptr) + off) % NREQ;
            shifted = r >> idx;
            if (shifted[0]) begin
                pick = IDW'(idx);
            end
        end
        return pick;
    endfunction

    // Break the packed operand buses into per-requester lanes so the winner
    // can select its operands with a plain array index.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            lane_a[i] = req_a[i*OP_W +: OP_W];
            lane_b[i] = req_b[i*OP_W +: OP_W];
        end
    end

    // Arbitration is evaluated every cycle but only acted on in IDLE.
    always_comb begin
        any_req = |req;
        winner  = rr_pick(req, rr_ptr);
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the grant pulse. A grant only ever issues from
    // IDLE, so at most one operation is in flight at a time.
    always_comb begin
        next_state = state;
        gnt        = '0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    gnt[winner] = 1'b1;
                    next_state  = ST_LO;
                end
            end
            ST_LO: begin
                next_state = op_wide ? ST_HI : ST_RESP;
            end
            ST_HI: begin
                next_state = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // The adder sees the low halves and the requester's carry-in during LO,
    // and the high halves with the carry from the low pass during HI.
    always_comb begin
        add_a = op_a[LANE_W-1:0];
        add_b = op_b[LANE_W-1:0];
        add_c = op_cin;
        if (state == ST_HI) begin
            add_a = op_a[OP_W-1:LANE_W];
            add_b = op_b[OP_W-1:LANE_W];
            add_c = carry;
        end
    end

    adder_32bit u_adder (
        .Sum  (add_sum),
        .Cout (add_cout),
        .A    (add_a),
        .B    (add_b),
        .C    (add_c)
    );

    // Operand capture on grant, then one register update per adder pass.
    // The high half is cleared on the low pass so narrow results come back
    // with a zero upper word. Nothing here moves while in RESP, which keeps
    // the response stable under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= IDW'(NREQ - 1);
            op_a    <= '0;
            op_b    <= '0;
            op_cin  <= 1'b0;
            op_wide <= 1'b0;
            op_id   <= '0;
            lo      <= '0;
            hi      <= '0;
            carry   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        op_a    <= lane_a[winner];
                        op_b    <= lane_b[winner];
                        op_cin  <= req_cin[winner];
                        op_wide <= req_wide[winner];
                        op_id   <= winner;
                        rr_ptr  <= winner;
                    end
                end
                ST_LO: begin
                    lo    <= add_sum;
                    hi    <= '0;
                    carry <= add_cout;
                end
                ST_HI: begin
                    hi    <= add_sum;
                    carry <= add_cout;
                end
                default: begin
                end
            endcase
        end
    end

    // Status and response outputs come straight from state and registers.
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_id    = op_id;
    assign rsp_sum   = {hi, lo};
    assign rsp_cout  = carry;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_share_arbiter
//   Self-checking bench for adder_share_arbiter. Expected results come from a
//   plain-arithmetic reference: a single 64-bit (or 32-bit) addition for the
//   sum and a "walk forward from the last winner" rule for arbitration.
// ---------------------------------------------------------------------------
module tb_adder_share_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 30;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_wide;
    logic [NREQ*64-1:0] req_a;
    logic [NREQ*64-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [63:0]       rsp_sum;
    logic              rsp_cout;

    logic [63:0]       lane_a [NREQ];
    logic [63:0]       lane_b [NREQ];

    int checks;
    int failures;
    int cyc;
    int model_ptr;

    adder_share_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_wide  (req_wide),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    // Pack the per-lane operand arrays onto the DUT's flat buses.
    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_a[g*64 +: 64] = lane_a[g];
        assign req_b[g*64 +: 64] = lane_b[g];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference sum: one full-width addition; bit 64 is the carry out.
    function automatic logic [64:0] model_add(input logic wide, input logic [63:0] a,
                                              input logic [63:0] b, input logic cin);
        logic [64:0] full;
        logic [32:0] narrow;
        if (wide) begin
            full = {1'b0, a} + {1'b0, b} + 65'(cin);
            return full;
        end
        narrow = {1'b0, a[31:0]} + {1'b0, b[31:0]} + 33'(cin);
        return {narrow[32], 32'h0, narrow[31:0]};
    endfunction

    // Reference arbitration: starting after the last winner, the first
    // requester met while walking forward (with wrap) wins.
    function automatic int model_next(input int last, input logic [NREQ-1:0] mask);
        int cand;
        cand = last;
        repeat (NREQ) begin
            cand = (cand + 1) % NREQ;
            if (mask[cand]) return cand;
        end
        return -1;
    endfunction

    task automatic fill_junk();
        for (int i = 0; i < NREQ; i++) begin
            lane_a[i] = {$urandom, $urandom};
            lane_b[i] = {$urandom, $urandom};
        end
        req_wide = NREQ'($urandom);
        req_cin  = NREQ'($urandom);
    endtask

    task automatic apply_reset(input int ncyc);
        @(negedge clk);
        reset     = 1'b1;
        req       = '0;
        rsp_ready = 1'b0;
        repeat (ncyc) @(negedge clk);
        reset     = 1'b0;
        model_ptr = NREQ - 1;
    endtask

    // Issue one request on lane idx with rsp_ready held high and report what
    // was observed: the grant vector, cycles from grant to rsp_valid, and the
    // response fields. Bounded on both waits.
    task automatic apply_stimulus(input int idx, input logic wide, input logic [63:0] a,
                                  input logic [63:0] b, input logic cin,
                                  output logic [NREQ-1:0] g, output int lat,
                                  output logic [IDW-1:0] id, output logic [63:0] sum,
                                  output logic cout);
        int n;
        g = '0; lat = TIMEOUT; id = '0; sum = '0; cout = 1'b0;
        @(negedge clk);
        lane_a[idx]   = a;
        lane_b[idx]   = b;
        req_wide[idx] = wide;
        req_cin[idx]  = cin;
        rsp_ready     = 1'b1;
        req           = '0;
        req[idx]      = 1'b1;
        #1;
        n = 0;
        while (gnt == '0 && n < TIMEOUT) begin
            @(negedge clk); #1; n++;
        end
        g = gnt;
        @(negedge clk);
        req = '0;
        if (g == '0) return;
        model_ptr = idx;
        #1;
        lat = 1;
        while (!rsp_valid && lat < TIMEOUT) begin
            @(negedge clk); #1; lat++;
        end
        if (!rsp_valid) return;
        id   = rsp_id;
        sum  = rsp_sum;
        cout = rsp_cout;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (gnt !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got gnt=%b busy=%b valid=%b expected 0000/0/0", gnt, busy, rsp_valid);
        end
        checks++;
        if (rsp_id !== '0 || rsp_sum !== 64'h0 || rsp_cout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_rsp: got id=%0d sum=%h cout=%b expected 0/0/0", rsp_id, rsp_sum, rsp_cout);
        end
        @(negedge clk);
        reset     = 1'b0;
        model_ptr = NREQ - 1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || gnt !== '0) begin
            failures++;
            $display("[TB] FAIL idle_no_req: got busy=%b gnt=%b expected 0/0000", busy, gnt);
        end
    endtask

    task automatic test_narrow();
        logic [NREQ-1:0] g, eg;
        int              lat, idx;
        logic [IDW-1:0]  id;
        logic [63:0]     sum, a, b;
        logic            cout, cin;
        logic [64:0]     exp;
        fill_junk();
        apply_stimulus(0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, g, lat, id, sum, cout);
        checks++;
        if (g !== 4'b0001) begin
            failures++; $display("[TB] FAIL narrow_gnt: got %b expected 0001", g);
        end
        checks++;
        if (lat !== 2) begin
            failures++; $display("[TB] FAIL narrow_latency: got %0d expected 2", lat);
        end
        checks++;
        if (id !== 2'd0 || sum !== 64'h0 || cout !== 1'b1) begin
            failures++; $display("[TB] FAIL narrow_result: got id=%0d sum=%h cout=%b expected 0/0/1", id, sum, cout);
        end
        for (int k = 0; k < 6; k++) begin
            fill_junk();
            idx = $urandom_range(0, NREQ-1);
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            cin = 1'($urandom);
            exp = model_add(1'b0, a, b, cin);
            eg  = '0; eg[idx] = 1'b1;
            apply_stimulus(idx, 1'b0, a, b, cin, g, lat, id, sum, cout);
            checks++;
            if (g !== eg || lat !== 2) begin
                failures++; $display("[TB] FAIL narrow_rand_timing: got gnt=%b lat=%0d expected %b/2", g, lat, eg);
            end
            checks++;
            if (id !== IDW'(idx) || {cout, sum} !== exp) begin
                failures++; $display("[TB] FAIL narrow_rand_result: got id=%0d %b_%h expected %0d %b_%h", id, cout, sum, idx, exp[64], exp[63:0]);
            end
        end
    endtask

    task automatic test_wide();
        logic [NREQ-1:0] g, eg;
        int              lat, idx;
        logic [IDW-1:0]  id;
        logic [63:0]     sum, a, b;
        logic            cout, cin;
        logic [64:0]     exp;
        fill_junk();
        apply_stimulus(2, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, g, lat, id, sum, cout);
        checks++;
        if (g !== 4'b0100 || lat !== 3) begin
            failures++; $display("[TB] FAIL wide_timing: got gnt=%b lat=%0d expected 0100/3", g, lat);
        end
        checks++;
        if (id !== 2'd2 || sum !== 64'h0000_0001_0000_0000 || cout !== 1'b0) begin
            failures++; $display("[TB] FAIL wide_result: got id=%0d sum=%h cout=%b expected 2/0000000100000000/0", id, sum, cout);
        end
        fill_junk();
        apply_stimulus(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, g, lat, id, sum, cout);
        checks++;
        if (g !== 4'b0010 || lat !== 3) begin
            failures++; $display("[TB] FAIL chain_timing: got gnt=%b lat=%0d expected 0010/3", g, lat);
        end
        checks++;
        if (id !== 2'd1 || sum !== 64'h0 || cout !== 1'b1) begin
            failures++; $display("[TB] FAIL chain_result: got id=%0d sum=%h cout=%b expected 1/0/1", id, sum, cout);
        end
        for (int k = 0; k < 6; k++) begin
            fill_junk();
            idx = $urandom_range(0, NREQ-1);
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            cin = 1'($urandom);
            exp = model_add(1'b1, a, b, cin);
            eg  = '0; eg[idx] = 1'b1;
            apply_stimulus(idx, 1'b1, a, b, cin, g, lat, id, sum, cout);
            checks++;
            if (g !== eg || lat !== 3) begin
                failures++; $display("[TB] FAIL wide_rand_timing: got gnt=%b lat=%0d expected %b/3", g, lat, eg);
            end
            checks++;
            if (id !== IDW'(idx) || {cout, sum} !== exp) begin
                failures++; $display("[TB] FAIL wide_rand_result: got id=%0d %b_%h expected %0d %b_%h", id, cout, sum, idx, exp[64], exp[63:0]);
            end
        end
    endtask

    task automatic test_contention();
        logic [64:0] exp_res [$];
        int          exp_id  [$];
        int          order   [$];
        int          gcyc    [$];
        int          n, w, eid, ptr;
        logic [64:0] r;
        apply_reset(2);
        fill_junk();
        req_wide = '0;
        @(negedge clk);
        req       = '1;
        rsp_ready = 1'b1;
        n = 0;
        while ((order.size() < 5 || exp_id.size() > 0) && n < 80) begin
            #1;
            if (gnt != '0) begin
                checks++;
                if ($countones(gnt) != 1) begin
                    failures++; $display("[TB] FAIL contention_onehot: got %b expected one-hot", gnt);
                end
                w = 0;
                for (int i = 0; i < NREQ; i++) if (gnt[i]) w = i;
                order.push_back(w);
                gcyc.push_back(cyc);
                exp_id.push_back(w);
                exp_res.push_back(model_add(1'b0, lane_a[w], lane_b[w], req_cin[w]));
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_id.size() == 0) begin
                    failures++; $display("[TB] FAIL contention_rsp: got unexpected response id=%0d expected none", rsp_id);
                end else begin
                    eid = exp_id.pop_front();
                    r   = exp_res.pop_front();
                    if (rsp_id !== IDW'(eid) || {rsp_cout, rsp_sum} !== r) begin
                        failures++; $display("[TB] FAIL contention_rsp: got id=%0d %b_%h expected %0d %b_%h", rsp_id, rsp_cout, rsp_sum, eid, r[64], r[63:0]);
                    end
                end
            end
            @(negedge clk);
            n++;
            if (order.size() >= 5) req = '0;
        end
        req = '0;
        checks++;
        if (order.size() != 5 || exp_id.size() != 0) begin
            failures++; $display("[TB] FAIL contention_timeout: got %0d grants, %0d pending expected 5/0", order.size(), exp_id.size());
        end
        ptr = model_ptr;
        for (int k = 0; k < order.size(); k++) begin
            ptr = model_next(ptr, 4'b1111);
            checks++;
            if (order[k] != ptr) begin
                failures++; $display("[TB] FAIL contention_order[%0d]: got %0d expected %0d", k, order[k], ptr);
            end
            if (k > 0) begin
                checks++;
                if (gcyc[k] - gcyc[k-1] != 3) begin
                    failures++; $display("[TB] FAIL contention_gap[%0d]: got %0d expected 3", k, gcyc[k] - gcyc[k-1]);
                end
            end
        end
        model_ptr = ptr;
    endtask

    task automatic test_backpressure();
        logic [IDW-1:0]  id0;
        logic [63:0]     sum0;
        logic            cout0;
        logic [64:0]     exp;
        int              n, ew;
        bit              stable_ok, extra_gnt;
        fill_junk();
        req_wide[1] = 1'b0;
        req_wide[2] = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        req       = 4'b0010;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            failures++; $display("[TB] FAIL bp_gnt1: got %b expected 0010", gnt);
        end
        model_ptr = 1;
        exp = model_add(1'b0, lane_a[1], lane_b[1], req_cin[1]);
        @(negedge clk);
        req = '0;
        #1;
        n = 0;
        while (!rsp_valid && n < TIMEOUT) begin
            @(negedge clk); #1; n++;
        end
        id0 = rsp_id; sum0 = rsp_sum; cout0 = rsp_cout;
        checks++;
        if (!rsp_valid || id0 !== 2'd1 || {cout0, sum0} !== exp) begin
            failures++; $display("[TB] FAIL bp_result: got valid=%b id=%0d %b_%h expected 1 1 %b_%h", rsp_valid, id0, cout0, sum0, exp[64], exp[63:0]);
        end
        req = 4'b1100;
        stable_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) req[3] = 1'b0;
            #1;
            if (!rsp_valid || !busy || gnt !== '0 || rsp_id !== id0 || rsp_sum !== sum0 || rsp_cout !== cout0)
                stable_ok = 1'b0;
        end
        checks++;
        if (!stable_ok) begin
            failures++; $display("[TB] FAIL bp_stable: got valid=%b gnt=%b id=%0d sum=%h expected 1/0000/%0d/%h", rsp_valid, gnt, rsp_id, rsp_sum, id0, sum0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (!rsp_valid || gnt !== '0) begin
            failures++; $display("[TB] FAIL bp_ready_cycle: got valid=%b gnt=%b expected 1/0000", rsp_valid, gnt);
        end
        ew = model_next(model_ptr, 4'b0100);
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || gnt !== NREQ'(1 << ew)) begin
            failures++; $display("[TB] FAIL bp_next_grant: got busy=%b gnt=%b expected 0/%b", busy, gnt, NREQ'(1 << ew));
        end
        model_ptr = ew;
        exp = model_add(1'b0, lane_a[2], lane_b[2], req_cin[2]);
        @(negedge clk);
        req = '0;
        #1;
        n = 0;
        while (!rsp_valid && n < TIMEOUT) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (!rsp_valid || rsp_id !== 2'd2 || {rsp_cout, rsp_sum} !== exp) begin
            failures++; $display("[TB] FAIL bp_second: got valid=%b id=%0d %b_%h expected 1 2 %b_%h", rsp_valid, rsp_id, rsp_cout, rsp_sum, exp[64], exp[63:0]);
        end
        extra_gnt = 1'b0;
        repeat (6) begin
            @(negedge clk); #1;
            if (gnt !== '0) extra_gnt = 1'b1;
        end
        checks++;
        if (extra_gnt) begin
            failures++; $display("[TB] FAIL dropped_req_granted: got a grant expected none");
        end
    endtask

    task automatic test_reset_mid_op();
        logic [64:0] exp;
        int          n;
        bit          quiet;
        fill_junk();
        lane_a[0]   = {$urandom, 32'h1234_5678};
        lane_b[0]   = {$urandom, 32'h0F0F_0F0F};
        req_wide[0] = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b1;
        req       = 4'b0001;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            failures++; $display("[TB] FAIL midrst_gnt: got %b expected 0001", gnt);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL midrst_in_hi: got busy=%b valid=%b expected 1/0", busy, rsp_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (gnt !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_sum !== 64'h0 || rsp_cout !== 1'b0) begin
            failures++; $display("[TB] FAIL midrst_outputs: got gnt=%b busy=%b valid=%b id=%0d sum=%h cout=%b expected all 0", gnt, busy, rsp_valid, rsp_id, rsp_sum, rsp_cout);
        end
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        model_ptr = NREQ - 1;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++; $display("[TB] FAIL midrst_dropped: got valid=%b busy=%b expected 0/0", rsp_valid, busy);
        end
        fill_junk();
        req_wide = '0;
        @(negedge clk);
        req = 4'b1010;
        #1;
        checks++;
        if (gnt !== NREQ'(1 << model_next(model_ptr, 4'b1010))) begin
            failures++; $display("[TB] FAIL midrst_first_gnt: got %b expected 0010", gnt);
        end
        model_ptr = 1;
        exp = model_add(1'b0, lane_a[1], lane_b[1], req_cin[1]);
        @(negedge clk);
        req = '0;
        #1;
        n = 0;
        while (!rsp_valid && n < TIMEOUT) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (!rsp_valid || rsp_id !== 2'd1 || {rsp_cout, rsp_sum} !== exp) begin
            failures++; $display("[TB] FAIL midrst_after: got valid=%b id=%0d %b_%h expected 1 1 %b_%h", rsp_valid, rsp_id, rsp_cout, rsp_sum, exp[64], exp[63:0]);
        end
    endtask

    task automatic test_random_arb();
        logic [NREQ-1:0] mask;
        logic [64:0]     exp;
        int              ew, n;
        bit              done;
        for (int k = 0; k < 12; k++) begin
            fill_junk();
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            ew   = model_next(model_ptr, mask);
            exp  = model_add(req_wide[ew], lane_a[ew], lane_b[ew], req_cin[ew]);
            @(negedge clk);
            req       = mask;
            rsp_ready = 1'($urandom);
            #1;
            checks++;
            if (gnt !== NREQ'(1 << ew)) begin
                failures++; $display("[TB] FAIL rand_arb_gnt[%0d]: got %b expected %b (mask %b)", k, gnt, NREQ'(1 << ew), mask);
            end
            model_ptr = ew;
            @(negedge clk);
            req  = '0;
            done = 1'b0;
            n    = 0;
            while (!done && n < TIMEOUT) begin
                rsp_ready = 1'($urandom);
                #1;
                if (rsp_valid && rsp_ready) begin
                    done = 1'b1;
                    checks++;
                    if (rsp_id !== IDW'(ew) || {rsp_cout, rsp_sum} !== exp) begin
                        failures++; $display("[TB] FAIL rand_arb_rsp[%0d]: got id=%0d %b_%h expected %0d %b_%h", k, rsp_id, rsp_cout, rsp_sum, ew, exp[64], exp[63:0]);
                    end
                end
                @(negedge clk);
                n++;
            end
            if (!done) begin
                checks++;
                failures++;
                $display("[TB] FAIL rand_arb_timeout[%0d]: got no response expected id %0d", k, ew);
            end
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 100000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        model_ptr = NREQ - 1;
        reset     = 1'b1;
        req       = '0;
        req_wide  = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            lane_a[i] = '0;
            lane_b[i] = '0;
        end
        $display("[TB] starting adder_share_arbiter bench");
        test_reset();
        test_narrow();
        test_wide();
        test_contention();
        test_backpressure();
        test_reset_mid_op();
        test_random_arb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
